// File: rtl/reindeer_mtimer_pkg.sv
// Shared definitions for the Reindeer machine timer: register map, CTRL bit
// positions, reset constants and the address-decode helper.
package reindeer_mtimer_pkg;

    localparam int unsigned TIMER_WIDTH = 64;

    localparam int unsigned TIMER_MTIME_LO    = 0;
    localparam int unsigned TIMER_MTIME_HI    = 1;
    localparam int unsigned TIMER_MTIMECMP_LO = 2;
    localparam int unsigned TIMER_MTIMECMP_HI = 3;
    localparam int unsigned TIMER_CTRL        = 4;
    localparam int unsigned TIMER_PRESCALE    = 5;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT  = 1;

    localparam logic [TIMER_WIDTH-1:0] MTIMECMP_RESET = '1;

    // The PRESCALE slot only decodes when the prescaler is built in.
    function automatic logic addr_mapped(input logic [31:0] addr, input logic prescale_en);
        return (addr <= (prescale_en ? TIMER_PRESCALE : TIMER_CTRL));
    endfunction

endpackage

// File: rtl/reindeer_mtimer_prescaler.sv
// Reload down-counter that paces mtime increments; tick_o is high for one cycle
// each time the count reaches zero. Only built when MTIME_PRESCALER_EN is defined.
`ifdef MTIME_PRESCALER_EN
module reindeer_mtimer_prescaler #(
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sync_reset_i,
    input  logic                     load_i,
    input  logic [PRESCALE_BITS-1:0] load_value_i,
    output logic [PRESCALE_BITS-1:0] prescale_o,
    output logic                     tick_o
);

    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [PRESCALE_BITS-1:0] count_q, count_d;

    always_comb begin
        prescale_d = prescale_q;
        count_d    = count_q;
        if (load_i) begin
            prescale_d = load_value_i;
        end
        // A PRESCALE write restarts the period from the new value on the same edge.
        if (sync_reset_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_value_i;
        end else if (count_q == '0) begin
            count_d = prescale_q;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prescale_q <= '0;
            count_q    <= '0;
        end else begin
            prescale_q <= prescale_d;
            count_q    <= count_d;
        end
    end

    assign prescale_o = prescale_q;
    assign tick_o     = (count_q == '0);

endmodule
`endif

// File: rtl/reindeer_mtimer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) feeding the CSR block's
// timer input. Optional prescaler at address 5 under MTIME_PRESCALER_EN.
module reindeer_mtimer
    import reindeer_mtimer_pkg::*;
#(
    parameter int unsigned TIMER_ADDR_BITS = 3,
    parameter int unsigned PRESCALE_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sync_reset,
    input  logic                       read_enable,
    input  logic [TIMER_ADDR_BITS-1:0] read_addr,
    output logic                       read_en_out,
    output logic [31:0]                read_data_out,
    input  logic                       write_enable,
    input  logic [TIMER_ADDR_BITS-1:0] write_addr,
    input  logic [31:0]                write_data_in,
    output logic                       timer_triggered,
    output logic                       addr_error
);

    logic [TIMER_WIDTH-1:0]   mtime_q, mtime_d;
    logic [TIMER_WIDTH-1:0]   mtimecmp_q, mtimecmp_d;
    logic [1:0]               ctrl_q, ctrl_d;
    logic [31:0]              snapshot_hi_q, snapshot_hi_d;
    logic                     cmp_hit_q, cmp_hit_d;
    logic                     read_en_q;
    logic [31:0]              read_data_q, read_data_d;
    logic                     addr_error_q, addr_error_d;
    logic                     tick;
    logic [PRESCALE_BITS-1:0] prescale_val;
    logic [31:0]              wa, ra;

    assign wa = 32'(write_addr);
    assign ra = 32'(read_addr);

`ifdef MTIME_PRESCALER_EN
    localparam logic PRESCALE_EN = 1'b1;

    logic prescale_we;
    assign prescale_we = write_enable && (wa == TIMER_PRESCALE);

    reindeer_mtimer_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk_i        (clk),
        .rst_i        (reset),
        .sync_reset_i (sync_reset),
        .load_i       (prescale_we),
        .load_value_i (write_data_in[PRESCALE_BITS-1:0]),
        .prescale_o   (prescale_val),
        .tick_o       (tick)
    );
`else
    localparam logic PRESCALE_EN = 1'b0;

    assign tick         = 1'b1;
    assign prescale_val = '0;
`endif

    // Counter and compare. Clearing on a match also drops cmp_hit so the
    // trigger is a single-cycle pulse once per period.
    always_comb begin
        mtime_d   = mtime_q;
        cmp_hit_d = (mtime_q >= mtimecmp_q);
        if (ctrl_q[CTRL_CLEAR_BIT] && cmp_hit_q) begin
            mtime_d   = '0;
            cmp_hit_d = 1'b0;
        end else if (ctrl_q[CTRL_ENABLE_BIT] && tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        // A software write replaces one half outright; the other half keeps its
        // pre-increment value and no carry crosses between them.
        if (write_enable && (wa == TIMER_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], write_data_in};
        end else if (write_enable && (wa == TIMER_MTIME_HI)) begin
            mtime_d = {write_data_in, mtime_q[31:0]};
        end
        if (sync_reset) begin
            mtime_d   = '0;
            cmp_hit_d = 1'b0;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        if (write_enable) begin
            if (wa == TIMER_MTIMECMP_LO) begin
                mtimecmp_d = {mtimecmp_q[63:32], write_data_in};
            end else if (wa == TIMER_MTIMECMP_HI) begin
                mtimecmp_d = {write_data_in, mtimecmp_q[31:0]};
            end else if (wa == TIMER_CTRL) begin
                ctrl_d = write_data_in[1:0];
            end
        end
    end

    // Reads see pre-write state. A LO read freezes the upper half so the
    // following HI read is coherent with it.
    always_comb begin
        read_data_d   = read_data_q;
        snapshot_hi_d = snapshot_hi_q;
        if (read_enable) begin
            case (ra)
                TIMER_MTIME_LO: begin
                    read_data_d   = mtime_q[31:0];
                    snapshot_hi_d = mtime_q[63:32];
                end
                TIMER_MTIME_HI:    read_data_d = snapshot_hi_q;
                TIMER_MTIMECMP_LO: read_data_d = mtimecmp_q[31:0];
                TIMER_MTIMECMP_HI: read_data_d = mtimecmp_q[63:32];
                TIMER_CTRL:        read_data_d = {30'd0, ctrl_q};
                TIMER_PRESCALE:    read_data_d = PRESCALE_EN ? 32'(prescale_val) : 32'd0;
                default:           read_data_d = 32'd0;
            endcase
        end
    end

    assign addr_error_d = (read_enable  && !addr_mapped(ra, PRESCALE_EN)) ||
                          (write_enable && !addr_mapped(wa, PRESCALE_EN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q       <= '0;
            mtimecmp_q    <= MTIMECMP_RESET;
            ctrl_q        <= '0;
            snapshot_hi_q <= '0;
            cmp_hit_q     <= 1'b0;
            read_en_q     <= 1'b0;
            read_data_q   <= '0;
            addr_error_q  <= 1'b0;
        end else begin
            mtime_q       <= mtime_d;
            mtimecmp_q    <= mtimecmp_d;
            ctrl_q        <= ctrl_d;
            snapshot_hi_q <= snapshot_hi_d;
            cmp_hit_q     <= cmp_hit_d;
            read_en_q     <= read_enable;
            read_data_q   <= read_data_d;
            addr_error_q  <= addr_error_d;
        end
    end

    assign read_en_out     = read_en_q;
    assign read_data_out   = read_data_q;
    assign addr_error      = addr_error_q;
    assign timer_triggered = cmp_hit_q & ctrl_q[CTRL_ENABLE_BIT];

endmodule
